// File: rtl/op_io_pkg.sv
// rtl/op_io_pkg.sv - shared widths, key polarity and prescaler helper for the operator input stage
package op_io_pkg;

    localparam int   OPCODE_W    = 3;
    localparam int   OPREG_W     = 8;
    localparam int   CNT_W       = 8;
    localparam logic KEY_PRESSED = 1'b0;

    function automatic int ms_div(input int freq);
        return freq / 1000;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronizes and debounces one active-low key, emitting a press event
module key_debouncer
    import op_io_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= ~KEY_PRESSED;
            r_sync2    <= ~KEY_PRESSED;
            r_stable   <= ~KEY_PRESSED;
            r_stable_d <= ~KEY_PRESSED;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= raw_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any cycle of agreement restarts the count, so bounces never accumulate.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign press = (r_stable == KEY_PRESSED) && (r_stable_d != KEY_PRESSED);

endmodule

// File: rtl/op_input_ctrl.sv
// rtl/op_input_ctrl.sv - 1 ms timebase, key debounce, operand latch and opcode stepping for display_driver
module op_input_ctrl
    import op_io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          SW,
    input  logic                KEY_REG,
    input  logic                KEY_CODE,
    output logic                oneMsPulse,
    output logic [OPREG_W-1:0]  OpReg,
    output logic                ShowOpReg,
    output logic [OPCODE_W-1:0] OpCode,
    output logic                ShowOpCode,
    output logic                dispMode
);

    localparam int                MS_DIV   = ms_div(CLK_FREQ_HZ);
    localparam int                DIV_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(MS_DIV - 1);

    logic [DIV_W-1:0]    r_div;
    logic                r_one_ms;
    logic [OPREG_W-1:0]  r_sw_s1;
    logic [OPREG_W-1:0]  r_sw_s2;
    logic                r_mode_s1;
    logic                r_mode_s2;
    logic [OPREG_W-1:0]  r_op_reg;
    logic                r_show_reg;
    logic [OPCODE_W-1:0] r_op_code;
    logic                r_show_code;
    logic                r_code_pending;
    logic                w_reg_press;
    logic                w_code_press;
    logic                w_unused_sw8;

    assign w_unused_sw8 = SW[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_one_ms <= 1'b0;
        end else begin
            r_one_ms <= (r_div == DIV_LAST);
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_sw_s1   <= SW[7:0];
            r_sw_s2   <= r_sw_s1;
            r_mode_s1 <= SW[9];
            r_mode_s2 <= r_mode_s1;
        end
    end

    key_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (r_one_ms),
        .raw_n (KEY_REG),
        .press (w_reg_press)
    );

    key_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_code (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (r_one_ms),
        .raw_n (KEY_CODE),
        .press (w_code_press)
    );

    // Operand load wins a same-cycle collision; the opcode step is deferred one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_reg       <= '0;
            r_show_reg     <= 1'b0;
            r_op_code      <= '0;
            r_show_code    <= 1'b0;
            r_code_pending <= 1'b0;
        end else begin
            r_show_reg  <= 1'b0;
            r_show_code <= 1'b0;
            if (w_reg_press) begin
                r_op_reg   <= r_sw_s2;
                r_show_reg <= 1'b1;
                if (w_code_press) begin
                    r_code_pending <= 1'b1;
                end
            end else if (w_code_press || r_code_pending) begin
                r_op_code      <= r_op_code + 1'b1;
                r_show_code    <= 1'b1;
                r_code_pending <= 1'b0;
            end
        end
    end

    assign oneMsPulse = r_one_ms;
    assign OpReg      = r_op_reg;
    assign ShowOpReg  = r_show_reg;
    assign OpCode     = r_op_code;
    assign ShowOpCode = r_show_code;
    assign dispMode   = r_mode_s2;

endmodule

// File: tb/tb_op_input_ctrl.sv
// tb/tb_op_input_ctrl.sv - directed self-checking bench for op_input_ctrl (MS_DIV=10, DEBOUNCE_MS=3)
module tb_op_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] SW;
    logic       KEY_REG;
    logic       KEY_CODE;
    logic       oneMsPulse;
    logic [7:0] OpReg;
    logic       ShowOpReg;
    logic [2:0] OpCode;
    logic       ShowOpCode;
    logic       dispMode;

    int n_checks = 0;
    int n_fail   = 0;
    int n_reg    = 0;
    int n_code   = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    op_input_ctrl #(.CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SW         (SW),
        .KEY_REG    (KEY_REG),
        .KEY_CODE   (KEY_CODE),
        .oneMsPulse (oneMsPulse),
        .OpReg      (OpReg),
        .ShowOpReg  (ShowOpReg),
        .OpCode     (OpCode),
        .ShowOpCode (ShowOpCode),
        .dispMode   (dispMode)
    );

    always @(negedge clk) begin
        if (ShowOpReg === 1'b1)  n_reg++;
        if (ShowOpCode === 1'b1) n_code++;
        if (ShowOpReg === 1'b1 && ShowOpCode === 1'b1) n_both++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  r0;
        int  c0;
        bit  found;

        rst_n    = 1'b0;
        SW       = 10'h200;
        KEY_REG  = 1'b1;
        KEY_CODE = 1'b1;
        step(3);
        check("rst_pulse",    32'(oneMsPulse), 32'd0);
        check("rst_opreg",    32'(OpReg),      32'h00);
        check("rst_showreg",  32'(ShowOpReg),  32'd0);
        check("rst_opcode",   32'(OpCode),     32'd0);
        check("rst_showcode", 32'(ShowOpCode), 32'd0);
        check("rst_dispmode", 32'(dispMode),   32'd0);

        // Reset release: pulse at cycles 10, 20, 30; dispMode follows SW[9] after 2 cycles
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            check($sformatf("pulse_c%0d", k), 32'(oneMsPulse), (k % 10 == 0) ? 32'd1 : 32'd0);
            if (k == 1) check("dispmode_c1", 32'(dispMode), 32'd0);
            if (k == 2) check("dispmode_c2", 32'(dispMode), 32'd1);
        end

        // Bounced operand press and bounced release
        SW = 10'h0A5;
        step(5);
        r0 = n_reg;
        for (int i = 0; i < 10; i++) begin
            KEY_REG = ~KEY_REG;
            step(4);
        end
        KEY_REG = 1'b0;
        step(100);
        check("bounce_strobes", 32'(n_reg - r0), 32'd1);
        check("bounce_opreg",   32'(OpReg),      32'hA5);
        check("bounce_nocode",  32'(n_code),     32'd0);
        for (int i = 0; i < 10; i++) begin
            KEY_REG = ~KEY_REG;
            step(4);
        end
        KEY_REG = 1'b1;
        step(100);
        check("release_nostrobe", 32'(n_reg - r0), 32'd1);

        // Opcode wrap over 9 clean presses
        c0 = n_code;
        r0 = n_reg;
        for (int i = 0; i < 9; i++) begin
            KEY_CODE = 1'b0;
            step(50);
            KEY_CODE = 1'b1;
            step(50);
            check($sformatf("opcode_step%0d", i + 1), 32'(OpCode), 32'((i + 1) % 8));
        end
        check("opcode_strobes", 32'(n_code - c0), 32'd9);
        check("opcode_noreg",   32'(n_reg - r0),  32'd0);

        // Simultaneous press: ShowOpReg at N, ShowOpCode at N+1
        SW = 10'h03C;
        step(5);
        KEY_REG  = 1'b0;
        KEY_CODE = 1'b0;
        found    = 1'b0;
        for (int t = 0; t < 80 && !found; t++) begin
            step(1);
            if (ShowOpReg === 1'b1) found = 1'b1;
        end
        check("simul_found",     32'(found),      32'd1);
        check("simul_opreg",     32'(OpReg),      32'h3C);
        check("simul_code_at_n", 32'(ShowOpCode), 32'd0);
        step(1);
        check("simul_code_n1",   32'(ShowOpCode), 32'd1);
        check("simul_reg_n1",    32'(ShowOpReg),  32'd0);
        check("simul_opcode",    32'(OpCode),     32'd2);
        KEY_REG  = 1'b1;
        KEY_CODE = 1'b1;
        step(100);
        check("never_both", 32'(n_both), 32'd0);

        // Long hold with switch change mid-hold
        SW = 10'h05A;
        step(5);
        r0 = n_reg;
        KEY_REG = 1'b0;
        step(100);
        SW = 10'h0FF;
        step(400);
        KEY_REG = 1'b1;
        step(100);
        check("hold_strobes", 32'(n_reg - r0), 32'd1);
        check("hold_opreg",   32'(OpReg),      32'h5A);

        // Reset 2 ms into a press, released with keys still down
        SW = 10'h077;
        step(5);
        r0 = n_reg;
        c0 = n_code;
        KEY_REG  = 1'b0;
        KEY_CODE = 1'b0;
        step(20);
        rst_n = 1'b0;
        #1;
        check("midrst_opreg",  32'(OpReg),      32'h00);
        check("midrst_opcode", 32'(OpCode),     32'd0);
        check("midrst_pulse",  32'(oneMsPulse), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(15);
        KEY_REG  = 1'b1;
        KEY_CODE = 1'b1;
        step(150);
        check("midrst_noreg",   32'(n_reg - r0),  32'd0);
        check("midrst_nocode",  32'(n_code - c0), 32'd0);
        check("midrst_opreg2",  32'(OpReg),       32'h00);
        check("midrst_opcode2", 32'(OpCode),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
